dff_monitor: RTL and testbench

- Synthesizable checker that sits on the far side of the dff interface: it observes the d/clr/rst inputs driven into a dff instance and the q it returns.
- Runs a cycle-accurate reference model of the dff and compares every cycle.
- Reports pass/fail, error count and first-failing index to the bench or a status register.
- Replaces hand-checked waveforms with a self-checking result.

---
 rtl/dff_monitor.sv | 139 +++++++++++++
 tb/tb_dff_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_monitor.sv
// Cycle-accurate checker for a dff with clr > rst(set) > d priority: runs a
// reference model alongside the observed q and accumulates mismatch statistics.
module dff_monitor #(
    parameter int CNT_W       = 16,
    parameter int ERR_W       = 8,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_stat,
    input  logic [CNT_W-1:0] chk_len,
    input  logic             mon_d,
    input  logic             mon_clr,
    input  logic             mon_rst,
    input  logic             mon_q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err,
    output logic             exp_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_CHECK = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [CNT_W-1:0]   len_q,       len_d;
    logic               err_q,       err_d;
    logic [ERR_W-1:0]   err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0]   first_err_q, first_err_d;
    logic               model_q,     model_d;
    logic               done_q,      done_d;

    logic model_nxt;
    logic mismatch;
    logic last_cmp;

    assign model_nxt = mon_clr ? 1'b0 : (mon_rst ? 1'b1 : mon_d);
    // model_q holds what the dff should have captured on the previous edge
    assign mismatch  = (mon_q != model_q);
    assign last_cmp  = (cnt_q == len_q - 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            model_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            model_q     <= model_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        model_d     = model_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clr_stat || (en && chk_len != '0)) begin
                    err_d       = 1'b0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                end
                if (en && chk_len != '0) begin
                    state_d = S_SYNC;
                    len_d   = chk_len;
                    cnt_d   = '0;
                end
            end
            S_SYNC: begin
                model_d = model_nxt;
                state_d = en ? S_CHECK : S_IDLE;
            end
            S_CHECK: begin
                model_d = model_nxt;
                // dropping en aborts before the comparison on this edge counts
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (mismatch) begin
                        err_d = 1'b1;
                        if (err_cnt_q != ERR_MAX)
                            err_cnt_d = err_cnt_q + 1'b1;
                        if (!err_q)
                            first_err_d = cnt_q;
                    end
                    if ((STOP_ON_ERR != 0) && mismatch) begin
                        state_d = S_HALT;
                        done_d  = 1'b1;
                    end else if (last_cmp) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (!en)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q == S_SYNC) || (state_q == S_CHECK);
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;
    assign exp_q     = model_q;

endmodule

// File: tb/tb_dff_monitor.sv
// Bench for dff_monitor: one free-running instance and one halting instance
// share all inputs; each run checks the selected instance against a run model.
module tb_dff_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr_stat;
    logic [15:0] chk_len;
    logic        mon_d, mon_clr, mon_rst, mon_q;

    logic        busy0, done0, err0, exp0;
    logic [7:0]  ecnt0;
    logic [15:0] ferr0;
    logic        busy1, done1, err1, exp1;
    logic [7:0]  ecnt1;
    logic [15:0] ferr1;

    int checks = 0;
    int errors = 0;

    bit sd [0:511];
    bit sc [0:511];
    bit sr [0:511];
    bit inj[0:511];

    typedef struct {
        bit c;
        bit r;
        bit d;
        bit e;
    } vec_t;

    dff_monitor #(.CNT_W(16), .ERR_W(8), .STOP_ON_ERR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_stat(clr_stat), .chk_len(chk_len),
        .mon_d(mon_d), .mon_clr(mon_clr), .mon_rst(mon_rst), .mon_q(mon_q),
        .busy(busy0), .done(done0), .err(err0), .err_cnt(ecnt0),
        .first_err(ferr0), .exp_q(exp0)
    );

    dff_monitor #(.CNT_W(16), .ERR_W(8), .STOP_ON_ERR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_stat(clr_stat), .chk_len(chk_len),
        .mon_d(mon_d), .mon_clr(mon_clr), .mon_rst(mon_rst), .mon_q(mon_q),
        .busy(busy1), .done(done1), .err(err1), .err_cnt(ecnt1),
        .first_err(ferr1), .exp_q(exp1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic bit mdl(input bit c, input bit r, input bit d);
        if (c) return 1'b0;
        if (r) return 1'b1;
        return d;
    endfunction

    task automatic fill_rand(input int n);
        for (int i = 0; i <= n; i++) begin
            sc[i]  = ($urandom_range(0, 4) == 0);
            sr[i]  = ($urandom_range(0, 3) == 0);
            sd[i]  = 1'($urandom);
            inj[i] = 1'b0;
        end
    endtask

    task automatic chk_stats(input string nm, input bit sel, input int e, input int cnt, input int fe);
        chk({nm, " err"},       sel ? int'(err1)  : int'(err0),  e);
        chk({nm, " err_cnt"},   sel ? int'(ecnt1) : int'(ecnt0), cnt);
        chk({nm, " first_err"}, sel ? int'(ferr1) : int'(ferr0), fe);
    endtask

    // Drives one run of n comparisons from the stimulus arrays. Index j is the
    // edge after the start edge (j=0 is the sync edge, j>=1 is comparison j-1).
    task automatic run(input string nm, input int n, input bit sel, input int abort_at);
        int  cnt    = 0;
        int  first  = -1;
        int  halt_k = -1;
        bit  halted = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (abort_at >= 0 && k >= abort_at) break;
            if (inj[k]) begin
                cnt++;
                if (first < 0) first = k;
                if (sel) break;
            end
        end
        if (sel && first >= 0) halt_k = first;

        en = 1'b1;
        chk_len = 16'(n);
        step();
        chk({nm, " busy@start"}, sel ? int'(busy1) : int'(busy0), 1);
        chk({nm, " done@start"}, sel ? int'(done1) : int'(done0), 0);

        for (int j = 0; j <= n; j++) begin
            int k = j - 1;
            bit abort = (abort_at >= 0 && k == abort_at);
            bit last  = (j == n) || (halt_k >= 0 && k == halt_k);
            if (abort) en = 1'b0;
            mon_d   = sd[j];
            mon_clr = sc[j];
            mon_rst = sr[j];
            mon_q   = (j == 0) ? 1'($urandom) : (mdl(sc[j-1], sr[j-1], sd[j-1]) ^ inj[j-1]);
            step();
            if (abort) begin
                chk({nm, " busy@abort"}, sel ? int'(busy1) : int'(busy0), 0);
                chk({nm, " done@abort"}, sel ? int'(done1) : int'(done0), 0);
                break;
            end
            chk({nm, " exp_q"}, sel ? int'(exp1) : int'(exp0), int'(mdl(sc[j], sr[j], sd[j])));
            chk({nm, " busy"},  sel ? int'(busy1) : int'(busy0), last ? 0 : 1);
            chk({nm, " done"},  sel ? int'(done1) : int'(done0), last ? 1 : 0);
            if (last) begin
                halted = (j != n) || (halt_k == n - 1);
                if (!(halted && sel)) en = 1'b0;
                break;
            end
        end

        if (sel && halted) begin
            // statistics must hold in HALT, even against clr_stat
            clr_stat = 1'b1;
            for (int i = 0; i < 2; i++) begin
                step();
                chk({nm, " halt busy"}, int'(busy1), 0);
                chk({nm, " halt done"}, int'(done1), 0);
                chk_stats({nm, " halt"}, 1'b1, 1, cnt, first);
            end
            clr_stat = 1'b0;
            en = 1'b0;
        end
        step();
        chk({nm, " done once"}, sel ? int'(done1) : int'(done0), 0);
        chk({nm, " idle busy"}, sel ? int'(busy1) : int'(busy0), 0);
        chk_stats(nm, sel, (cnt > 0) ? 1 : 0, (cnt > 255) ? 255 : cnt, (first < 0) ? 0 : first);
    endtask

    initial begin
        vec_t tbl[8];
        int   n;

        tbl[0] = '{c:1, r:1, d:1, e:0};
        tbl[1] = '{c:0, r:1, d:0, e:1};
        tbl[2] = '{c:0, r:0, d:1, e:1};
        tbl[3] = '{c:0, r:0, d:0, e:0};
        tbl[4] = '{c:1, r:0, d:1, e:0};
        tbl[5] = '{c:0, r:1, d:1, e:1};
        tbl[6] = '{c:1, r:1, d:0, e:0};
        tbl[7] = '{c:0, r:0, d:1, e:1};

        rst_n = 1'b0; en = 1'b1; clr_stat = 1'b0; chk_len = 16'd5;
        mon_d = 1'b1; mon_clr = 1'b0; mon_rst = 1'b1; mon_q = 1'b1;
        step(); step();
        chk("rst busy",      int'(busy0), 0);
        chk("rst done",      int'(done0), 0);
        chk("rst exp_q",     int'(exp0),  0);
        chk_stats("rst", 1'b0, 0, 0, 0);
        chk("rst busy1",     int'(busy1), 0);
        en = 1'b0; rst_n = 1'b1;
        step();

        // chk_len==0 must not start a run
        en = 1'b1; chk_len = 16'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("len0 busy", int'(busy0), 0);
            chk("len0 done", int'(done0), 0);
        end
        en = 1'b0;
        step();

        // priority table: clr > rst > d
        en = 1'b1; chk_len = 16'd7;
        step();
        for (int i = 0; i < 8; i++) begin
            mon_clr = tbl[i].c; mon_rst = tbl[i].r; mon_d = tbl[i].d;
            mon_q   = (i == 0) ? 1'b0 : tbl[i-1].e;
            step();
            chk("prio exp_q", int'(exp0), int'(tbl[i].e));
            if (i == 7) begin
                chk("prio done", int'(done0), 1);
                en = 1'b0;
            end
        end
        step();
        chk_stats("prio", 1'b0, 0, 0, 0);

        // clean run: set, clear with d=1, then d toggling every 2 cycles
        n = 20;
        for (int i = 0; i <= n; i++) begin
            sr[i] = (i == 0); sc[i] = (i == 1);
            sd[i] = (i == 1) ? 1'b1 : 1'(((i - 2) / 2) % 2);
            inj[i] = 1'b0;
        end
        run("clean", n, 1'b0, -1);

        fill_rand(20);
        inj[5] = 1'b1; inj[9] = 1'b1;
        run("fault", 20, 1'b0, -1);

        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        chk_stats("clrstat", 1'b0, 0, 0, 0);

        fill_rand(20);
        inj[19] = 1'b1;
        run("lastmis", 20, 1'b0, -1);

        fill_rand(300);
        for (int i = 0; i < 300; i++) inj[i] = 1'b1;
        run("sat", 300, 1'b0, -1);

        fill_rand(20);
        inj[3] = 1'b1; inj[8] = 1'b1;
        run("halt", 20, 1'b1, -1);

        fill_rand(20);
        inj[19] = 1'b1;
        run("halt_last", 20, 1'b1, -1);

        fill_rand(20);
        inj[2] = 1'b1;
        run("abort", 20, 1'b0, 7);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(3, 40);
            fill_rand(n);
            for (int i = 0; i < n; i++) inj[i] = ($urandom_range(0, 7) == 0);
            run("rand", n, 1'(r % 2), (r == 4) ? int'($urandom_range(0, n - 1)) : -1);
        end

        // reset mid-run returns everything to reset values
        fill_rand(10);
        en = 1'b1; chk_len = 16'd10; mon_q = ~exp0;
        step(); step(); step(); step();
        rst_n = 1'b0; en = 1'b0;
        step();
        chk("midrst busy",  int'(busy0), 0);
        chk("midrst done",  int'(done0), 0);
        chk("midrst exp_q", int'(exp0),  0);
        chk_stats("midrst", 1'b0, 0, 0, 0);
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
